// File: rtl/game_sequencer.sv
// Game flow controller: sequences idle/play/pause/level-clear/end states, owns the
// level counter and issues the one-cycle control pulses consumed by the datapaths.
module game_sequencer #(
    parameter int num_levels_p   = 8,
    parameter int clear_frames_p = 60
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       frame_i,
    input  logic       start_i,
    input  logic       player_hit_i,
    input  logic [1:0] lives_i,
    input  logic       enemies_cleared_i,
    input  logic       enemies_landed_i,
    output logic       run_o,
    output logic       frame_o,
    output logic       resume_o,
    output logic       new_level_o,
    output logic       new_game_o,
    output logic       add_life_o,
    output logic [3:0] level_o,
    output logic [5:0] state_o,
    output logic       game_over_o,
    output logic       win_o
);

    localparam int CntW = $clog2(clear_frames_p + 1);
    localparam logic [CntW-1:0] ClearMax  = CntW'(clear_frames_p);
    localparam logic [3:0]      LastLevel = 4'(num_levels_p);

    typedef enum logic [5:0] {
        IDLE        = 6'b000001,
        PLAY        = 6'b000010,
        HIT_PAUSE   = 6'b000100,
        LEVEL_CLEAR = 6'b001000,
        GAME_OVER   = 6'b010000,
        WIN         = 6'b100000
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      level_q, level_d;
    logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
    logic            resume_q, resume_d;
    logic            new_level_q, new_level_d;
    logic            new_game_q, new_game_d;
    logic            add_life_q, add_life_d;
    logic [3:0]      level_inc;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            level_q     <= 4'd0;
            frame_cnt_q <= '0;
            resume_q    <= 1'b0;
            new_level_q <= 1'b0;
            new_game_q  <= 1'b0;
            add_life_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            resume_q    <= resume_d;
            new_level_q <= new_level_d;
            new_game_q  <= new_game_d;
            add_life_q  <= add_life_d;
        end
    end

    assign level_inc = (level_q < LastLevel) ? level_q + 4'd1 : level_q;

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;
        resume_d    = 1'b0;
        new_level_d = 1'b0;
        new_game_d  = 1'b0;
        add_life_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = PLAY;
                    level_d     = 4'd1;
                    new_game_d  = 1'b1;
                    new_level_d = 1'b1;
                end
            end
            PLAY: begin
                // Landing beats a hit, which beats clearing the grid.
                if (enemies_landed_i) begin
                    state_d = GAME_OVER;
                end else if (player_hit_i) begin
                    state_d = (lives_i == 2'd0) ? GAME_OVER : HIT_PAUSE;
                end else if (enemies_cleared_i) begin
                    if (level_q == LastLevel) begin
                        state_d = WIN;
                    end else begin
                        state_d     = LEVEL_CLEAR;
                        frame_cnt_d = '0;
                    end
                end
            end
            HIT_PAUSE: begin
                if (start_i) begin
                    state_d  = PLAY;
                    resume_d = 1'b1;
                end
            end
            LEVEL_CLEAR: begin
                if (frame_i) begin
                    if (frame_cnt_q != ClearMax) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                    if (frame_cnt_q == ClearMax - 1'b1) begin
                        state_d     = PLAY;
                        level_d     = level_inc;
                        new_level_d = 1'b1;
                        resume_d    = 1'b1;
                        add_life_d  = !level_inc[0] && (lives_i < 2'd3);
                    end
                end
            end
            GAME_OVER, WIN: begin
                if (start_i) begin
                    state_d     = PLAY;
                    level_d     = 4'd1;
                    new_game_d  = 1'b1;
                    new_level_d = 1'b1;
                    resume_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign run_o       = (state_q == PLAY);
    assign frame_o     = frame_i & run_o;
    assign game_over_o = (state_q == GAME_OVER);
    assign win_o       = (state_q == WIN);
    assign state_o     = state_q;
    assign level_o     = level_q;
    assign resume_o    = resume_q;
    assign new_level_o = new_level_q;
    assign new_game_o  = new_game_q;
    assign add_life_o  = add_life_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with two levels and a
// three-frame level-clear interval.
module tb_game_sequencer;

    localparam int NumLevels   = 2;
    localparam int ClearFrames = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_in, start_in, hit_in, cleared_in, landed_in;
    logic [1:0] lives_in;
    logic       run, frame_out, resume, new_level, new_game, add_life;
    logic       game_over, win;
    logic [3:0] level;
    logic [5:0] state;

    int errors = 0;
    int checks = 0;

    game_sequencer #(.num_levels_p(NumLevels), .clear_frames_p(ClearFrames)) dut (
        .clk_i            (clk),
        .reset_ni         (reset_n),
        .frame_i          (frame_in),
        .start_i          (start_in),
        .player_hit_i     (hit_in),
        .lives_i          (lives_in),
        .enemies_cleared_i(cleared_in),
        .enemies_landed_i (landed_in),
        .run_o            (run),
        .frame_o          (frame_out),
        .resume_o         (resume),
        .new_level_o      (new_level),
        .new_game_o       (new_game),
        .add_life_o       (add_life),
        .level_o          (level),
        .state_o          (state),
        .game_over_o      (game_over),
        .win_o            (win)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic applyStimulus;
        @(posedge clk);
        #1;
    endtask

    task automatic checkPulses(input string tag, input logic g, input logic l, input logic r,
                               input logic a);
        checkOutput({tag, ".new_game"}, 8'(new_game), 8'(g));
        checkOutput({tag, ".new_level"}, 8'(new_level), 8'(l));
        checkOutput({tag, ".resume"}, 8'(resume), 8'(r));
        checkOutput({tag, ".add_life"}, 8'(add_life), 8'(a));
    endtask

    // One frame tick lasting a single cycle.
    task automatic frameTick;
        frame_in = 1'b1;
        applyStimulus();
        frame_in = 1'b0;
    endtask

    task automatic pressStart;
        start_in = 1'b1;
        applyStimulus();
        start_in = 1'b0;
    endtask

    task automatic clearLevel(input string tag, input logic [1:0] lives, input logic exp_add);
        lives_in   = lives;
        cleared_in = 1'b1;
        applyStimulus();
        cleared_in = 1'b0;
        checkOutput({tag, ".enter_clear"}, 8'(state), 8'h08);
        frameTick();
        applyStimulus();
        frameTick();
        checkOutput({tag, ".still_clear"}, 8'(state), 8'h08);
        checkPulses({tag, ".quiet"}, 1'b0, 1'b0, 1'b0, 1'b0);
        frameTick();
        checkOutput({tag, ".state"}, 8'(state), 8'h02);
        checkOutput({tag, ".level"}, 8'(level), 8'd2);
        checkPulses({tag, ".exit"}, 1'b0, 1'b1, 1'b1, exp_add);
        applyStimulus();
        checkPulses({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n    = 1'b0;
        frame_in   = 1'b0;
        start_in   = 1'b0;
        hit_in     = 1'b0;
        cleared_in = 1'b0;
        landed_in  = 1'b0;
        lives_in   = 2'd2;
        #12;
        checkOutput("reset.state", 8'(state), 8'h01);
        checkOutput("reset.level", 8'(level), 8'd0);
        checkOutput("reset.run", 8'(run), 8'd0);
        checkOutput("reset.end", 8'({game_over, win}), 8'd0);
        checkPulses("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        applyStimulus();
        checkOutput("idle.hold", 8'(state), 8'h01);

        pressStart();
        checkOutput("start.state", 8'(state), 8'h02);
        checkOutput("start.level", 8'(level), 8'd1);
        checkPulses("start", 1'b1, 1'b1, 1'b0, 1'b0);
        frame_in = 1'b1;
        #1;
        checkOutput("play.frame_hi", 8'(frame_out), 8'd1);
        frame_in = 1'b0;
        #1;
        checkOutput("play.frame_lo", 8'(frame_out), 8'd0);
        applyStimulus();
        checkPulses("start.after", 1'b0, 1'b0, 1'b0, 1'b0);
        pressStart();
        checkOutput("play.start_ignored", 8'(state), 8'h02);
        checkPulses("play.start_ignored", 1'b0, 1'b0, 1'b0, 1'b0);

        hit_in = 1'b1;
        lives_in = 2'd2;
        applyStimulus();
        hit_in = 1'b0;
        checkOutput("hit.state", 8'(state), 8'h04);
        checkOutput("hit.run", 8'(run), 8'd0);
        for (int i = 0; i < 100; i++) begin
            frame_in = 1'b1;
            #1;
            checkOutput("pause.frame_gated", 8'(frame_out), 8'd0);
            applyStimulus();
            frame_in = 1'b0;
        end
        checkOutput("pause.hold", 8'(state), 8'h04);
        pressStart();
        checkOutput("resume.state", 8'(state), 8'h02);
        checkPulses("resume", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        checkPulses("resume.after", 1'b0, 1'b0, 1'b0, 1'b0);

        clearLevel("clear1", 2'd1, 1'b1);

        cleared_in = 1'b1;
        applyStimulus();
        checkOutput("win.state", 8'(state), 8'h20);
        checkOutput("win.flags", 8'({game_over, win}), 8'b01);
        checkOutput("win.level", 8'(level), 8'd2);
        applyStimulus();
        cleared_in = 1'b0;
        checkOutput("win.hold", 8'(state), 8'h20);
        checkPulses("win.quiet", 1'b0, 1'b0, 1'b0, 1'b0);
        pressStart();
        checkOutput("restart.state", 8'(state), 8'h02);
        checkOutput("restart.level", 8'(level), 8'd1);
        checkPulses("restart", 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus();

        clearLevel("clear_full", 2'd3, 1'b0);

        landed_in  = 1'b1;
        hit_in     = 1'b1;
        cleared_in = 1'b1;
        lives_in   = 2'd1;
        applyStimulus();
        landed_in  = 1'b0;
        hit_in     = 1'b0;
        cleared_in = 1'b0;
        checkOutput("all.state", 8'(state), 8'h10);
        checkOutput("all.flags", 8'({game_over, win}), 8'b10);
        pressStart();
        checkOutput("go_restart.level", 8'(level), 8'd1);
        checkPulses("go_restart", 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus();

        hit_in   = 1'b1;
        start_in = 1'b1;
        lives_in = 2'd0;
        applyStimulus();
        hit_in   = 1'b0;
        start_in = 1'b0;
        checkOutput("lastlife.state", 8'(state), 8'h10);
        applyStimulus();
        checkOutput("lastlife.no_start", 8'(state), 8'h10);
        checkPulses("lastlife.quiet", 1'b0, 1'b0, 1'b0, 1'b0);
        pressStart();
        checkOutput("lastlife.restart", 8'(state), 8'h02);
        applyStimulus();

        lives_in   = 2'd1;
        cleared_in = 1'b1;
        applyStimulus();
        cleared_in = 1'b0;
        frameTick();
        frameTick();
        checkOutput("rst.in_clear", 8'(state), 8'h08);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst.state", 8'(state), 8'h01);
        checkOutput("rst.level", 8'(level), 8'd0);
        frame_in = 1'b1;
        applyStimulus();
        frame_in = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frameTick();
            checkOutput("rst.idle", 8'(state), 8'h01);
            checkPulses("rst.quiet", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game flow controller that sequences the player ship, bullet and enemy datapaths through a game. It owns the level counter, gates the per-frame tick to the datapaths while play is active, and issues the resume, new-level, new-game and extra-life pulses the player block consumes (`shoot_i`, `add_life_i`, and its reset). It sits between the debounced button and frame-tick logic and the player/enemy blocks.

## Interface
- `num_levels_p`, default 8: last level; clearing it wins the game (legal range 1..15).
- `clear_frames_p`, default 60: frames spent in `LEVEL_CLEAR` before the next level starts (≥1).
- `clk_i` input 1: clock.
- `reset_ni` input 1: asynchronous active-low reset.
- `frame_i` input 1: one-cycle frame tick.
- `start_i` input 1: debounced one-cycle center-button pulse.
- `player_hit_i` input 1: player struck by an enemy bullet (level).
- `lives_i` input 2: player lives remaining, sampled at hit.
- `enemies_cleared_i` input 1: all enemies destroyed (level).
- `enemies_landed_i` input 1: enemy formation reached the player row (level).
- `run_o` output 1: high only in `PLAY`.
- `frame_o` output 1: `frame_i & run_o`; the datapaths' frame input.
- `resume_o` output 1: one-cycle pulse; drives player `shoot_i` on resume.
- `new_level_o` output 1: one-cycle pulse; reloads the enemy grid and bullets.
- `new_game_o` output 1: one-cycle pulse; resets score and lives.
- `add_life_o` output 1: one-cycle pulse; drives player `add_life_i`.
- `level_o` output 4: current level, 0 in `IDLE` after reset.
- `state_o` output 6: one-hot state for debug.
- `game_over_o` output 1, `win_o` output 1: high in `GAME_OVER` / `WIN`.

## Operation
- The one-hot FSM state register is updated on the `clk_i` rising edge. Reset forces `IDLE`.
- **`IDLE` (6'b000001)**
  - `start_i` → `PLAY`; `level` ← 1; pulse `new_game_o` and `new_level_o`.
- **`PLAY` (6'b000010)**: priority is landed > hit > cleared.
  - `enemies_landed_i` → `GAME_OVER`.
  - `player_hit_i & lives_i==0` → `GAME_OVER`.
  - `player_hit_i & lives_i!=0` → `HIT_PAUSE`.
  - `enemies_cleared_i & level==num_levels_p` → `WIN`.
  - `enemies_cleared_i` (any other level) → `LEVEL_CLEAR`; the frame counter clears to 0.
  - `start_i` is ignored.
- **`HIT_PAUSE` (6'b000100)**
  - `start_i` → `PLAY`; pulse `resume_o`.
  - All other inputs are ignored.
- **`LEVEL_CLEAR` (6'b001000)**
  - Each `frame_i` increments the frame counter.
  - On the `frame_i` that brings the count to `clear_frames_p`: → `PLAY`; `level` ← `level+1`; pulse `new_level_o` and `resume_o`.
  - In the same cycle, pulse `add_life_o` if the new level is even and `lives_i<3`.
  - `start_i` is ignored.
- **`GAME_OVER` (6'b010000)** and **`WIN` (6'b100000)**
  - `start_i` → `PLAY`; `level` ← 1; pulse `new_game_o`, `new_level_o` and `resume_o`.
- Frame counter width is `$clog2(clear_frames_p+1)`. It saturates and does not wrap.
- `level` is 4 bits wide and never exceeds `num_levels_p`.
- Any illegal (non-one-hot) state returns to `IDLE` on the next edge.

## Timing
- Reset values (asynchronous, immediate):
  - `state_o` = 6'b000001, `level_o` = 0.
  - All pulse outputs = 0; `run_o`, `frame_o`, `game_over_o`, `win_o` = 0.
  - Frame counter = 0.
- Transitions: an input sampled at edge N moves the state at edge N.
  - Pulse outputs are registered: high for exactly the one cycle after edge N, the first cycle in the new state.
  - `level_o` updates at the same edge.
- `run_o` and `game_over_o`/`win_o` are decoded from the state register (no added latency).
  - `frame_o` is combinational from `frame_i` and `run_o`, so the frame that causes exit from `PLAY` still passes through.
- Level inputs held high produce only one transition. Pulses never repeat without a new state entry.
- `start_i` coincident with the transition into `HIT_PAUSE`/`GAME_OVER` is not acted on; a fresh pulse is required.
- `reset_ni` low mid-operation clears everything asynchronously. Pulses in flight are dropped.

## Test plan
- Reset, then `start_i` → `new_game_o` and `new_level_o` high for 1 cycle, `level_o`=1, `state_o`=6'b000010, and `frame_o` follows `frame_i`.
- In `PLAY`, `player_hit_i` with `lives_i`=2 → `HIT_PAUSE` and `frame_o`=0 for 100 frames; then `start_i` → `resume_o` for 1 cycle and back to `PLAY`.
- `clear_frames_p`=3 at level 1, `enemies_cleared_i` → exactly 3 `frame_i` in `LEVEL_CLEAR`, then `level_o`=2, `new_level_o`=1, and `add_life_o`=1 with `lives_i`=1 (but 0 with `lives_i`=3).
- `enemies_landed_i`, `player_hit_i` and `enemies_cleared_i` all high together → `GAME_OVER`; then `start_i` → `level_o`=1, `new_game_o` pulse.
- `num_levels_p`=2: clear level 1, then clear level 2 → `WIN`, `win_o`=1, `level_o` stays 2.
- `reset_ni` low during `LEVEL_CLEAR` with count=2 → immediate `IDLE`, `level_o`=0, and no pulses after release.
